// File: rtl/rl_mem_pkg.sv
// Shared types for the RAM-backed FIFO slice.
// Output-stage state and depth helper.
package rl_mem_pkg;

  typedef enum logic [1:0] {
    OS_EMPTY = 2'd0,
    OS_ONE   = 2'd1,
    OS_TWO   = 2'd2
  } os_state_t;

  // Depth of a RAM with the given address width; never below one.
  function automatic int depth_of(input int abits);
    return (abits <= 0) ? 1 : (1 << abits);
  endfunction

endpackage

// File: rtl/rl_fifo_skid2.sv
// Two-entry output stage behind the RAM read port.
// Entry 0 is the FIFO head; entry 1 absorbs a late arrival.
module rl_fifo_skid2
  import rl_mem_pkg::*;
#(
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [DBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic [1:0]       occupancy
);

  os_state_t        state;
  os_state_t        state_nxt;
  logic [DBITS-1:0] e0;
  logic [DBITS-1:0] e1;
  logic [DBITS-1:0] e0_nxt;
  logic [DBITS-1:0] e1_nxt;
  logic             pop;
  logic             ovf;

  assign out_valid = (state != OS_EMPTY);
  assign out_data  = e0;
  assign occupancy = state;
  assign pop       = out_valid & out_ready;

  // Next state and entry movement; arrivals fill entry 0 first.
  always_comb begin
    state_nxt = state;
    e0_nxt    = e0;
    e1_nxt    = e1;
    ovf       = 1'b0;
    unique case (state)
      OS_EMPTY: begin
        if (in_valid) begin
          e0_nxt    = in_data;
          state_nxt = OS_ONE;
        end
      end
      OS_ONE: begin
        if (pop && in_valid) begin
          e0_nxt = in_data;
        end else if (pop) begin
          state_nxt = OS_EMPTY;
        end else if (in_valid) begin
          e1_nxt    = in_data;
          state_nxt = OS_TWO;
        end
      end
      OS_TWO: begin
        if (pop) begin
          e0_nxt = e1;
          if (in_valid) begin
            e1_nxt = in_data;
          end else begin
            state_nxt = OS_ONE;
          end
        end else if (in_valid) begin
          ovf = 1'b1;
        end
      end
      default: state_nxt = OS_EMPTY;
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= OS_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data entries carry no reset; validity lives in state.
  always_ff @(posedge clk) begin
    e0 <= e0_nxt;
    e1 <= e1_nxt;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (clr) !ovf
  );

endmodule

// File: rtl/rl_ram_1r1w_generic.sv
// Simple dual-port RAM, 1 write + 1 read port.
// Registered read data, valid one cycle after re_i.
module rl_ram_1r1w_generic #(
  parameter int ABITS = 8,
  parameter int DBITS = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ABITS-1:0]         waddr_i,
  input  logic [DBITS-1:0]         din_i,
  input  logic [(DBITS+7)/8-1:0]   be_i,
  input  logic                     re_i,
  input  logic [ABITS-1:0]         raddr_i,
  output logic [DBITS-1:0]         dout_o
);

  logic [DBITS-1:0] mem [2**ABITS];

  // Byte-enabled write port.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DBITS; i++) begin
      if (we_i && be_i[i/8]) begin
        mem[waddr_i][i] <= din_i[i];
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      dout_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/rl_fifo_1r1w_ctrl.sv
// FWFT FIFO controller for an external 1R1W RAM.
// Prefetches into a 2-entry stage to hide read latency.
module rl_fifo_1r1w_ctrl
  import rl_mem_pkg::*;
#(
  parameter int ABITS = 8,
  parameter int DBITS = 8,
  parameter int AFULL = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic [DBITS-1:0]       wdata_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DBITS-1:0]       rdata_o,
  output logic [ABITS+1:0]       level_o,
  output logic                   almost_full_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  output logic                   ram_re_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam int DEPTH = depth_of(ABITS);
  localparam logic [ABITS:0] DEPTH_C = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_C = (ABITS+1)'(AFULL);

  logic             clr;
  logic             full;
  logic             push;
  logic             pop;
  logic             re;
  logic             inflight;
  logic             af;
  logic [1:0]       os_cnt;
  logic [2:0]       os_need;
  logic [ABITS-1:0] wptr;
  logic [ABITS-1:0] rptr;
  logic [ABITS:0]   ram_cnt;
  logic [ABITS:0]   ram_cnt_nxt;
  logic [ABITS:0]   free_nxt;

  // Flush behaves like reset and wins over any push or pop.
  assign clr  = rst_i | flush_i;
  assign full = (ram_cnt == DEPTH_C);
  assign push = wvalid_i & ~full & ~clr;
  assign pop  = rvalid_o & rready_i;

  // Read only when the stage has room after this cycle's pop.
  assign os_need = 3'(os_cnt) + 3'(inflight) - 3'(pop);
  assign re = (ram_cnt != '0) & (os_need < 3'd2) & ~clr;

  assign ram_cnt_nxt = ram_cnt
                     + (ABITS+1)'(push)
                     - (ABITS+1)'(re);
  assign free_nxt = DEPTH_C - ram_cnt_nxt;

  assign wready_o      = ~full;
  assign ram_we_o      = push;
  assign ram_waddr_o   = wptr;
  assign ram_din_o     = wdata_i;
  assign ram_be_o      = '1;
  assign ram_re_o      = re;
  assign ram_raddr_o   = rptr;
  assign almost_full_o = af;
  assign level_o = (ABITS+2)'(ram_cnt)
                 + (ABITS+2)'(inflight)
                 + (ABITS+2)'(os_cnt);

  // Write/read pointers wrap naturally at the RAM depth.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ABITS'(1);
      if (re)   rptr <= rptr + ABITS'(1);
    end
  end

  // RAM occupancy, read-in-flight flag and almost-full flag.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      ram_cnt  <= '0;
      inflight <= 1'b0;
      af       <= 1'b0;
    end else begin
      ram_cnt  <= ram_cnt_nxt;
      inflight <= re;
      af       <= (free_nxt <= AF_C);
    end
  end

  rl_fifo_skid2 #(
    .DBITS(DBITS)
  ) u_os (
    .clk       (clk_i),
    .clr       (clr),
    .in_valid  (inflight),
    .in_data   (ram_dout_i),
    .out_valid (rvalid_o),
    .out_ready (rready_i),
    .out_data  (rdata_o),
    .occupancy (os_cnt)
  );

  a_cnt_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    ram_cnt <= DEPTH_C
  );

  a_hold: assert property (
    @(posedge clk_i) disable iff (clr)
    (rvalid_o && !rready_i) |=> $stable(rdata_o)
  );

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Bench for rl_fifo_1r1w_ctrl with a generic RAM.
// Queue model plus directed literal checks.
module tb_rl_fifo_1r1w_ctrl;

  localparam int ABITS = 3;
  localparam int DBITS = 8;
  localparam int AFULL = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       wvalid_i = 1'b0;
  logic       wready_o;
  logic [7:0] wdata_i = '0;
  logic       rvalid_o;
  logic       rready_i = 1'b0;
  logic [7:0] rdata_o;
  logic [4:0] level_o;
  logic       almost_full_o;
  logic [2:0] ram_waddr_o;
  logic [7:0] ram_din_o;
  logic       ram_we_o;
  logic [0:0] ram_be_o;
  logic [2:0] ram_raddr_o;
  logic       ram_re_o;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  rl_fifo_1r1w_ctrl #(
    .ABITS(ABITS), .DBITS(DBITS), .AFULL(AFULL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .wvalid_i      (wvalid_i),
    .wready_o      (wready_o),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rready_i      (rready_i),
    .rdata_o       (rdata_o),
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
    .ram_waddr_o   (ram_waddr_o),
    .ram_din_o     (ram_din_o),
    .ram_we_o      (ram_we_o),
    .ram_be_o      (ram_be_o),
    .ram_raddr_o   (ram_raddr_o),
    .ram_re_o      (ram_re_o),
    .ram_dout_i    (ram_dout)
  );

  rl_ram_1r1w_generic #(
    .ABITS(ABITS), .DBITS(DBITS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we_o),
    .waddr_i (ram_waddr_o),
    .din_i   (ram_din_o),
    .be_i    (ram_be_o),
    .re_i    (ram_re_o),
    .raddr_i (ram_raddr_o),
    .dout_o  (ram_dout)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: contents are pushes minus pops;
  // RAM addresses follow accepted pushes and issued reads.
  logic [7:0] q[$];
  int  wa = 0;
  int  ra = 0;
  bit  armed = 0;
  logic exp_we;

  always @(negedge clk) begin
    if (armed) begin
      chk("level", 32'(level_o), 32'(q.size()));
      chk("level_max", 32'(level_o <= 5'd10), 1);
      if (q.size() == 0) chk("rvalid_empty", 32'(rvalid_o), 0);
      if (rvalid_o && q.size() > 0)
        chk("rdata", 32'(rdata_o), 32'(q[0]));
      exp_we = wvalid_i & wready_o & ~rst_i & ~flush_i;
      chk("ram_we", 32'(ram_we_o), 32'(exp_we));
      if (ram_we_o) begin
        chk("waddr", 32'(ram_waddr_o), 32'(wa % 8));
        chk("din", 32'(ram_din_o), 32'(wdata_i));
      end
      if (ram_re_o) chk("raddr", 32'(ram_raddr_o), 32'(ra % 8));
      chk("be", 32'(ram_be_o), 1);
      if (q.size() <= 7) chk("wready_free", 32'(wready_o), 1);
      if (q.size() >= 10) chk("wready_full", 32'(wready_o), 0);
      if (q.size() >= 7) chk("af_high", 32'(almost_full_o), 1);
      if (q.size() <= 3) chk("af_low", 32'(almost_full_o), 0);
    end
    if (rst_i || flush_i) begin
      q.delete();
      wa = 0;
      ra = 0;
      if (rst_i) armed = 1;
    end else if (armed) begin
      if (rvalid_o && rready_i && q.size() > 0) void'(q.pop_front());
      if (wvalid_i && wready_o) begin
        q.push_back(wdata_i);
        wa++;
      end
      if (ram_re_o) ra++;
    end
  end

  task automatic do_reset();
    wvalid_i = 0;
    rready_i = 0;
    flush_i = 0;
    rst_i = 1;
    @(negedge clk);
    tick();
    rst_i = 0;
  endtask

  task automatic wait_rvalid(input string name);
    int n = 0;
    @(negedge clk);
    while (!rvalid_o && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_timeout"}, 32'(rvalid_o), 1);
  endtask

  int i_push, popped, bubbles, ww, wr, n;
  bit primed;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    // 1: single word latency
    do_reset();
    @(negedge clk);
    chk("t1_rst_rvalid", 32'(rvalid_o), 0);
    chk("t1_rst_wready", 32'(wready_o), 1);
    chk("t1_rst_level", 32'(level_o), 0);
    chk("t1_rst_re", 32'(ram_re_o), 0);
    tick();
    wvalid_i = 1; wdata_i = 8'h11; rready_i = 1;
    @(negedge clk);
    chk("t1_we", 32'(ram_we_o), 1);
    chk("t1_rv0", 32'(rvalid_o), 0);
    tick();
    wvalid_i = 0;
    @(negedge clk);
    chk("t1_re", 32'(ram_re_o), 1);
    chk("t1_rv1", 32'(rvalid_o), 0);
    tick();
    @(negedge clk);
    chk("t1_rv2", 32'(rvalid_o), 0);
    chk("t1_lvl2", 32'(level_o), 1);
    tick();
    @(negedge clk);
    chk("t1_rv3", 32'(rvalid_o), 1);
    chk("t1_data", 32'(rdata_o), 32'h11);
    tick();
    @(negedge clk);
    chk("t1_rv4", 32'(rvalid_o), 0);
    chk("t1_lvl4", 32'(level_o), 0);

    // 2: fill to full, refuse extra push, drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wvalid_i = 1; wdata_i = 8'(i);
      tick();
    end
    wvalid_i = 1; wdata_i = 8'hEE;
    @(negedge clk);
    chk("t2_level", 32'(level_o), 10);
    chk("t2_wready", 32'(wready_o), 0);
    chk("t2_af", 32'(almost_full_o), 1);
    chk("t2_we", 32'(ram_we_o), 0);
    tick();
    wvalid_i = 0;
    tick();
    rready_i = 1;
    for (int i = 0; i < 10; i++) begin
      wait_rvalid("t2_pop");
      chk("t2_data", 32'(rdata_o), 32'(i));
      if (i == 1) chk("t2_wready_back", 32'(wready_o), 1);
      tick();
    end
    @(negedge clk);
    chk("t2_empty", 32'(level_o), 0);
    rready_i = 0;

    // 3: full-rate streaming with wrap counting
    do_reset();
    i_push = 0; popped = 0; bubbles = 0;
    ww = 0; wr = 0; primed = 0;
    rready_i = 1;
    for (int c = 0; c < 400 && popped < 200; c++) begin
      wvalid_i = (i_push < 200);
      wdata_i = 8'(i_push);
      @(negedge clk);
      if (wvalid_i && wready_o) i_push++;
      if (ram_we_o && ram_waddr_o == 3'd7) ww++;
      if (ram_re_o && ram_raddr_o == 3'd7) wr++;
      if (rvalid_o) begin
        primed = 1;
        chk("t3_seq", 32'(rdata_o), 32'(popped));
        popped++;
      end else if (primed) begin
        bubbles++;
      end
      tick();
    end
    wvalid_i = 0;
    chk("t3_pushed", 32'(i_push), 200);
    chk("t3_popped", 32'(popped), 200);
    chk("t3_bubbles", 32'(bubbles), 0);
    chk("t3_wwrap", 32'(ww), 25);
    chk("t3_rwrap", 32'(wr), 25);

    // 4: random traffic against the model
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      wvalid_i = 1'($urandom_range(0, 1));
      wdata_i = 8'($urandom_range(0, 255));
      rready_i = 1'($urandom_range(0, 1));
      tick();
    end
    wvalid_i = 0;
    rready_i = 1;
    n = 0;
    @(negedge clk);
    while (level_o != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_drain", 32'(level_o), 0);
    tick();

    // 5: flush with a read in flight and a same-cycle push
    do_reset();
    rready_i = 0;
    for (int i = 0; i < 7; i++) begin
      wvalid_i = 1; wdata_i = 8'(8'h50 + i);
      tick();
    end
    wvalid_i = 0; rready_i = 1;
    @(negedge clk);
    chk("t5_re", 32'(ram_re_o), 1);
    chk("t5_head", 32'(rdata_o), 32'h50);
    tick();
    rready_i = 0; flush_i = 1;
    wvalid_i = 1; wdata_i = 8'h77;
    @(negedge clk);
    chk("t5_lvl6", 32'(level_o), 6);
    tick();
    flush_i = 0; wvalid_i = 0;
    @(negedge clk);
    chk("t5_lvl0", 32'(level_o), 0);
    chk("t5_rv0", 32'(rvalid_o), 0);
    chk("t5_wready", 32'(wready_o), 1);
    chk("t5_af", 32'(almost_full_o), 0);
    tick();
    @(negedge clk);
    chk("t5_rv_idle", 32'(rvalid_o), 0);
    tick();
    wvalid_i = 1; wdata_i = 8'hA5; rready_i = 1;
    tick();
    wvalid_i = 0;
    wait_rvalid("t5_a5");
    chk("t5_a5", 32'(rdata_o), 32'hA5);
    tick();
    @(negedge clk);
    chk("t5_end", 32'(level_o), 0);

    // 6: reset in the middle of traffic
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wvalid_i = 1; wdata_i = 8'(8'h60 + i);
      tick();
    end
    wvalid_i = 0;
    wait_rvalid("t6_fill");
    tick();
    rst_i = 1; wvalid_i = 1; wdata_i = 8'h99; rready_i = 1;
    tick();
    rst_i = 0; wvalid_i = 0; rready_i = 0;
    @(negedge clk);
    chk("t6_rv", 32'(rvalid_o), 0);
    chk("t6_lvl", 32'(level_o), 0);
    chk("t6_wready", 32'(wready_o), 1);
    chk("t6_af", 32'(almost_full_o), 0);
    chk("t6_we", 32'(ram_we_o), 0);
    chk("t6_re", 32'(ram_re_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t6_stale", 32'(rvalid_o), 0);
    end
    tick();
    wvalid_i = 1; wdata_i = 8'h3C; rready_i = 1;
    tick();
    wvalid_i = 0;
    wait_rvalid("t6_3c");
    chk("t6_3c", 32'(rdata_o), 32'h3C);
    tick();
    @(negedge clk);
    chk("t6_end", 32'(level_o), 0);
    rready_i = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
